seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector, successor to the fixed 3-bit detector FSM.
//  - Matches a runtime-loadable PATTERN_W-bit pattern on a qualified serial input.
//  - Overlapping or non-overlapping detection is selectable at runtime.
//  - Drives a one-cycle match pulse and a saturating match counter with a sticky saturation flag.
//  - Sits on the serial front end, feeding the framing/status logic.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 45 ++++
 rtl/seq_detector_param.sv | 143 ++++++++++++++
 tb/tb_seq_detector_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int unsigned DEF_PATTERN_W   = 3;
    localparam logic [2:0]  DEF_PATTERN_RST = 3'b010;
    localparam int unsigned DEF_CNT_W       = 10;

    // Width of a counter able to hold 0..pattern_w valid bits.
    function automatic int unsigned fill_w(input int unsigned pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky saturation flag; clear has priority.
module sat_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // Next count: clear first, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && !(&count_q)) begin
                count_d = count_q + CNT_W'(1);
            end
            sat_d = sat_q | (&count_d);
        end
    end

    // Counter state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime pattern load,
// selectable overlap and a saturating match counter.
// Optional feature macro: SEQDET_MASK_EN adds a don't-care mask (mask_in).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PATTERN_W   = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(DEF_PATTERN_RST),
    parameter int unsigned          CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 xin,
    input  logic                 pattern_ld,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic                 overlap,
    input  logic                 clr_count,
`ifdef SEQDET_MASK_EN
    input  logic [PATTERN_W-1:0] mask_in,
`endif
    output logic                 y,
    output logic [CNT_W-1:0]     count,
    output logic                 count_sat
);

    localparam int unsigned          FILL_W    = fill_w(PATTERN_W);
    localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(PATTERN_W - 1);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(PATTERN_W);

    // Only the previous PATTERN_W-1 bits are stored; the live window is {hist, xin}.
    logic [PATTERN_W-2:0] hist_q, hist_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    state_t               state_q, state_d;
    logic                 y_q, y_d;
    logic [PATTERN_W-1:0] win_new;
    logic                 hit;
    logic                 match;

`ifdef SEQDET_MASK_EN
    logic [PATTERN_W-1:0] mask_q, mask_d;

    // Masked compare: mask bit 0 marks a don't-care position.
    always_comb begin
        win_new = {hist_q, xin};
        hit     = (((win_new ^ pattern_q) & mask_q) == '0);
    end
`else
    // Exact compare of the window including the current bit.
    always_comb begin
        win_new = {hist_q, xin};
        hit     = (win_new == pattern_q);
    end
`endif

    // Next-state logic: load beats shift, en=0 freezes everything.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        y_d       = 1'b0;
        match     = 1'b0;
`ifdef SEQDET_MASK_EN
        mask_d    = mask_q;
`endif
        if (pattern_ld) begin
            pattern_d = pattern_in;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = FILL;
`ifdef SEQDET_MASK_EN
            mask_d    = mask_in;
`endif
        end else if (en) begin
            hist_d = win_new[PATTERN_W-2:0];
            case (state_q)
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = ARMED;
                        fill_d  = FILL_FULL;
                        match   = hit;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ARMED: begin
                    match = hit;
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
            if (match) begin
                y_d = 1'b1;
                // Non-overlapping mode demands PATTERN_W fresh bits for the next match.
                if (!overlap) begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            end
        end
    end

    // Detector state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FILL;
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN_RST;
            y_q       <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            y_q       <= y_d;
`ifdef SEQDET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (clr_count),
        .count (count),
        .sat   (count_sat)
    );

    assign y = y_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (3-bit/10-bit and 4-bit/2-bit)
// share one stimulus stream; a bit-history model predicts every output.
module tb_seq_detector_param;

    localparam int unsigned PW_A = 3;
    localparam int unsigned CW_A = 10;
    localparam int unsigned PW_B = 4;
    localparam int unsigned CW_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, en, xin, pattern_ld, overlap, clr_count;
    logic [PW_A-1:0] pin_a;
    logic [PW_B-1:0] pin_b;
    logic            y_a, y_b, sat_a, sat_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    seq_detector_param #(
        .PATTERN_W   (PW_A),
        .PATTERN_RST (3'b010),
        .CNT_W       (CW_A)
    ) u_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .xin        (xin),
        .pattern_ld (pattern_ld),
        .pattern_in (pin_a),
        .overlap    (overlap),
        .clr_count  (clr_count),
        .y          (y_a),
        .count      (cnt_a),
        .count_sat  (sat_a)
    );

    seq_detector_param #(
        .PATTERN_W   (PW_B),
        .PATTERN_RST (4'b1111),
        .CNT_W       (CW_B)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .xin        (xin),
        .pattern_ld (pattern_ld),
        .pattern_in (pin_b),
        .overlap    (overlap),
        .clr_count  (clr_count),
        .y          (y_b),
        .count      (cnt_b),
        .count_sat  (sat_b)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    int pulses_a = 0;
    int pulses_b = 0;

    // Model: keep all bits seen since the last flush; match when enough fresh
    // bits exist and the newest PATTERN_W of them equal the pattern.
    int          m_pw   [2] = '{3, 4};
    int unsigned m_cmax [2] = '{1023, 3};
    logic [31:0] m_pat  [2];
    logic [63:0] m_hist [2];
    int          m_n    [2];
    bit          m_y    [2];
    int unsigned m_cnt  [2];
    bit          m_sat  [2];

    always @(posedge clk) begin
        logic [31:0] pin_k;
        logic [31:0] wmask;
        bit          hit;
        for (int k = 0; k < 2; k++) begin
            pin_k = (k == 0) ? 32'(pin_a) : 32'(pin_b);
            wmask = (32'd1 << m_pw[k]) - 32'd1;
            hit   = 1'b0;
            if (!rst) begin
                m_pat[k]  = (k == 0) ? 32'h2 : 32'hF;
                m_hist[k] = '0;
                m_n[k]    = 0;
                m_y[k]    = 1'b0;
                m_cnt[k]  = 0;
                m_sat[k]  = 1'b0;
            end else begin
                if (pattern_ld) begin
                    m_pat[k] = pin_k;
                    m_n[k]   = 0;
                end else if (en) begin
                    m_hist[k] = {m_hist[k][62:0], xin};
                    if (m_n[k] < 64) m_n[k] = m_n[k] + 1;
                    hit = (m_n[k] >= m_pw[k]) && ((m_hist[k][31:0] & wmask) == m_pat[k]);
                    if (hit && !overlap) m_n[k] = 0;
                end
                m_y[k] = hit;
                if (clr_count) begin
                    m_cnt[k] = 0;
                    m_sat[k] = 1'b0;
                end else if (hit && m_cnt[k] < m_cmax[k]) begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (m_cnt[k] == m_cmax[k]) m_sat[k] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("y_a",   32'(y_a),   32'(m_y[0]));
            check("cnt_a", 32'(cnt_a), m_cnt[0]);
            check("sat_a", 32'(sat_a), 32'(m_sat[0]));
            check("y_b",   32'(y_b),   32'(m_y[1]));
            check("cnt_b", 32'(cnt_b), m_cnt[1]);
            check("sat_b", 32'(sat_b), 32'(m_sat[1]));
            pulses_a += int'(y_a);
            pulses_b += int'(y_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        en  = 1'b1;
        xin = b;
        tick();
        en  = 1'b0;
    endtask

    task automatic gap();
        en = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int p0;

    initial begin
        rst = 1'b0; en = 1'b0; xin = 1'b0; pattern_ld = 1'b0;
        overlap = 1'b1; clr_count = 1'b0; pin_a = 3'b010; pin_b = 4'b1101;
        tick();
        chk_on = 1'b1;
        tick();
        check("rst_y",   32'(y_a),   32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_sat", 32'(sat_a), 32'd0);
        rst = 1'b1;

        // 1: overlapping 0,1,0,1,0 -> two matches
        overlap = 1'b1;
        p0 = pulses_a;
        bit_in(0); bit_in(1); bit_in(0);
        check("t1_y_bit3", 32'(y_a), 32'd1);
        bit_in(1); bit_in(0);
        check("t1_y_bit5", 32'(y_a), 32'd1);
        gap();
        check("t1_pulses", 32'(pulses_a - p0), 32'd2);
        check("t1_cnt",    32'(cnt_a), 32'd2);
        check("t1_model_cnt", m_cnt[0], 32'd2);

        // 2: same stream non-overlapping -> one match
        do_reset();
        overlap = 1'b0;
        p0 = pulses_a;
        bit_in(0); bit_in(1); bit_in(0);
        check("t2_y_bit3", 32'(y_a), 32'd1);
        bit_in(1); bit_in(0);
        check("t2_y_bit5", 32'(y_a), 32'd0);
        gap();
        check("t2_pulses", 32'(pulses_a - p0), 32'd1);
        check("t2_cnt",    32'(cnt_a), 32'd1);

        // 3: load 1101 into the 4-bit instance, bits separated by en=0 gaps
        overlap = 1'b1;
        pin_b = 4'b1101;
        pattern_ld = 1'b1; tick(); pattern_ld = 1'b0;
        p0 = pulses_b;
        bit_in(1); gap(); bit_in(1); gap(); gap(); bit_in(0); gap();
        check("t3_no_early", 32'(pulses_b - p0), 32'd0);
        bit_in(1);
        check("t3_y", 32'(y_b), 32'd1);
        gap();
        check("t3_pulses", 32'(pulses_b - p0), 32'd1);
        check("t3_cnt",    32'(cnt_b), 32'd1);

        // 4: 2-bit counter saturates at the 3rd match; clear beats 5th match
        do_reset();
        pattern_ld = 1'b1; tick(); pattern_ld = 1'b0;
        bit_in(1); bit_in(1); bit_in(0); bit_in(1);
        bit_in(1); bit_in(0); bit_in(1);
        check("t4_cnt2", 32'(cnt_b), 32'd2);
        check("t4_sat2", 32'(sat_b), 32'd0);
        bit_in(1); bit_in(0); bit_in(1);
        check("t4_cnt3", 32'(cnt_b), 32'd3);
        check("t4_sat3", 32'(sat_b), 32'd1);
        check("t4_model_sat", 32'(m_sat[1]), 32'd1);
        bit_in(1); bit_in(0); bit_in(1);
        check("t4_y4",    32'(y_b),   32'd1);
        check("t4_hold4", 32'(cnt_b), 32'd3);
        bit_in(1); bit_in(0);
        clr_count = 1'b1;
        bit_in(1);
        clr_count = 1'b0;
        check("t4_clr_y",   32'(y_b),   32'd1);
        check("t4_clr_cnt", 32'(cnt_b), 32'd0);
        check("t4_clr_sat", 32'(sat_b), 32'd0);
        gap();

        // 5: reset mid-pattern, then a fresh 0,1,0 matches
        do_reset();
        overlap = 1'b1;
        bit_in(0); bit_in(1);
        rst = 1'b0; en = 1'b1; xin = 1'b0;
        tick();
        rst = 1'b1; en = 1'b0;
        check("t5_rst_y",   32'(y_a),   32'd0);
        check("t5_rst_cnt", 32'(cnt_a), 32'd0);
        bit_in(0);
        check("t5_no_match", 32'(y_a), 32'd0);
        bit_in(1); bit_in(0);
        check("t5_fresh", 32'(y_a), 32'd1);
        gap();

        // 6: pattern load on a would-match bit discards it and flushes history
        do_reset();
        p0 = pulses_a;
        bit_in(0); bit_in(1);
        pin_a = 3'b010; pattern_ld = 1'b1; en = 1'b1; xin = 1'b0;
        tick();
        pattern_ld = 1'b0; en = 1'b0;
        check("t6_ld_y", 32'(y_a), 32'd0);
        bit_in(1); bit_in(0);
        check("t6_flushed", 32'(y_a), 32'd0);
        bit_in(1); bit_in(0);
        check("t6_refill", 32'(y_a), 32'd1);
        gap();
        check("t6_pulses", 32'(pulses_a - p0), 32'd1);

        gap(); gap();
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
